// File: rtl/divpipe_pkg.sv
// Shared types and the single restoring-division step used by every divpipe stage.
// The stage bundle is sized for the default 64/32 configuration.
package divpipe_pkg;

    localparam int DP_W      = 32;
    localparam int DP_TAGW   = 4;
    localparam int DP_STAGES = 4;
    localparam int DP_MAXW   = 64;

    typedef struct packed {
        logic                 vld;
        logic [DP_W:0]        acc;
        logic [2*DP_W-1:0]    xrem;
        logic [DP_W-1:0]      q;
        logic [DP_W-1:0]      d;
        logic [DP_TAGW-1:0]   tag;
        logic                 ovf;
    } divpipe_bundle_t;

    // Operands are zero-extended to DP_MAXW so one function serves every width up to it.
    // Returns {qbit, acc_next}.
    function automatic logic [DP_MAXW+1:0] divpipe_step(
        input logic [DP_MAXW:0]   acc,
        input logic               xbit,
        input logic [DP_MAXW-1:0] d
    );
        logic [DP_MAXW:0] sh;
        sh = {acc[DP_MAXW-1:0], xbit};
        if (sh >= {1'b0, d}) begin
            return {1'b1, sh - {1'b0, d}};
        end
        return {1'b0, sh};
    endfunction

endpackage

// File: rtl/divpipe_stage.sv
// One divpipe pipeline stage: B unrolled restoring-division iterations feeding a register set
// that loads only when the whole pipe advances. Carries ovf only when DIVPIPE_OVF_EN is defined.
module divpipe_stage
    import divpipe_pkg::*;
#(
    parameter int W    = 32,
    parameter int B    = 8,
    parameter int TAGW = 4
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            adv,
    input  logic            vld_i,
    input  logic [W:0]      acc_i,
    input  logic [2*W-1:0]  xrem_i,
    input  logic [W-1:0]    quo_i,
    input  logic [W-1:0]    d_i,
    input  logic [TAGW-1:0] tag_i,
`ifdef DIVPIPE_OVF_EN
    input  logic            ovf_i,
    output logic            ovf_o,
`endif
    output logic            vld_o,
    output logic [W:0]      acc_o,
    output logic [2*W-1:0]  xrem_o,
    output logic [W-1:0]    quo_o,
    output logic [W-1:0]    d_o,
    output logic [TAGW-1:0] tag_o
);

    logic            vld_q,  vld_d;
    logic [W:0]      acc_q,  acc_d,  acc_c;
    logic [2*W-1:0]  xrem_q, xrem_d, xrem_c;
    logic [W-1:0]    quo_q,  quo_d,  quo_c;
    logic [W-1:0]    dv_q,   dv_d;
    logic [TAGW-1:0] tag_q,  tag_d;
    logic [DP_MAXW:0]   acc_w;
    logic [DP_MAXW-1:0] d_w;
    logic [DP_MAXW+1:0] step;

    always_comb begin
        acc_c  = acc_i;
        xrem_c = xrem_i;
        quo_c  = quo_i;
        acc_w  = '0;
        d_w    = '0;
        step   = '0;
        d_w[W-1:0] = d_i;
        for (int i = 0; i < B; i++) begin
            acc_w      = '0;
            acc_w[W:0] = acc_c;
            step   = divpipe_step(acc_w, xrem_c[2*W-1], d_w);
            xrem_c = {xrem_c[2*W-2:0], 1'b0};
            quo_c  = {quo_c[W-2:0], step[DP_MAXW+1]};
            acc_c  = step[W:0];
        end

        vld_d  = vld_q;
        acc_d  = acc_q;
        xrem_d = xrem_q;
        quo_d  = quo_q;
        dv_d   = dv_q;
        tag_d  = tag_q;
        if (adv) begin
            vld_d  = vld_i;
            acc_d  = acc_c;
            xrem_d = xrem_c;
            quo_d  = quo_c;
            dv_d   = d_i;
            tag_d  = tag_i;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_q  <= 1'b0;
            acc_q  <= '0;
            xrem_q <= '0;
            quo_q  <= '0;
            dv_q   <= '0;
            tag_q  <= '0;
        end else begin
            vld_q  <= vld_d;
            acc_q  <= acc_d;
            xrem_q <= xrem_d;
            quo_q  <= quo_d;
            dv_q   <= dv_d;
            tag_q  <= tag_d;
        end
    end

`ifdef DIVPIPE_OVF_EN
    logic ovf_q, ovf_d;

    always_comb begin
        ovf_d = adv ? ovf_i : ovf_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) ovf_q <= 1'b0;
        else       ovf_q <= ovf_d;
    end

    assign ovf_o = ovf_q;
`endif

    assign vld_o  = vld_q;
    assign acc_o  = acc_q;
    assign xrem_o = xrem_q;
    assign quo_o  = quo_q;
    assign d_o    = dv_q;
    assign tag_o  = tag_q;

endmodule

// File: rtl/divpipe.sv
// Fully pipelined restoring unsigned 2W/W divider with valid/ready backpressure and a tag.
// Define DIVPIPE_OVF_EN to add the ovf output (quotient saturates, remainder zeroed).
module divpipe
    import divpipe_pkg::*;
#(
    parameter int W      = 32,
    parameter int STAGES = 4,
    parameter int TAGW   = 4
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2*W-1:0]  x,
    input  logic [W-1:0]    d,
    input  logic [TAGW-1:0] in_tag,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W-1:0]    q,
    output logic [W-1:0]    r,
`ifdef DIVPIPE_OVF_EN
    output logic            ovf,
`endif
    output logic [TAGW-1:0] out_tag
);

    localparam int B = W / STAGES;

    logic            adv;
    logic            vld_s  [STAGES+1];
    logic [W:0]      acc_s  [STAGES+1];
    logic [2*W-1:0]  xrem_s [STAGES+1];
    logic [W-1:0]    quo_s  [STAGES+1];
    logic [W-1:0]    d_s    [STAGES+1];
    logic [TAGW-1:0] tag_s  [STAGES+1];
`ifdef DIVPIPE_OVF_EN
    logic            ovf_s  [STAGES+1];
    assign ovf_s[0] = (x[2*W-1:W] >= d);
`endif

    assign vld_s[0]  = in_valid;
    assign acc_s[0]  = {1'b0, x[2*W-1:W]};
    assign xrem_s[0] = {x[W-1:0], {W{1'b0}}};
    assign quo_s[0]  = '0;
    assign d_s[0]    = d;
    assign tag_s[0]  = in_tag;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        divpipe_stage #(.W(W), .B(B), .TAGW(TAGW)) u_stage (
            .clk    (clk),
            .rstn   (rstn),
            .adv    (adv),
            .vld_i  (vld_s[k]),
            .acc_i  (acc_s[k]),
            .xrem_i (xrem_s[k]),
            .quo_i  (quo_s[k]),
            .d_i    (d_s[k]),
            .tag_i  (tag_s[k]),
`ifdef DIVPIPE_OVF_EN
            .ovf_i  (ovf_s[k]),
            .ovf_o  (ovf_s[k+1]),
`endif
            .vld_o  (vld_s[k+1]),
            .acc_o  (acc_s[k+1]),
            .xrem_o (xrem_s[k+1]),
            .quo_o  (quo_s[k+1]),
            .d_o    (d_s[k+1]),
            .tag_o  (tag_s[k+1])
        );
    end

    // Whole pipe moves or holds as one; bubbles are held too so a stalled output never slips.
    assign out_valid = vld_s[STAGES];
    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;
    assign out_tag   = tag_s[STAGES];

    always_comb begin
        q = quo_s[STAGES];
        r = acc_s[STAGES][W-1:0];
`ifdef DIVPIPE_OVF_EN
        if (ovf_s[STAGES]) begin
            q = '1;
            r = '0;
        end
`endif
    end

`ifdef DIVPIPE_OVF_EN
    assign ovf = ovf_s[STAGES];
`endif

endmodule

// File: tb/tb_divpipe.sv
// Directed and random checks of divpipe (W=32, STAGES=4) against a 64-bit divide reference.
// The ovf scenario is compiled only when DIVPIPE_OVF_EN is defined.
module tb_divpipe;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] x = '0;
    logic [31:0] d = '0;
    logic [3:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] q, r;
    logic [3:0]  out_tag;
`ifdef DIVPIPE_OVF_EN
    logic        ovf;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    divpipe #(.W(32), .STAGES(4), .TAGW(4)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .d         (d),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q         (q),
        .r         (r),
`ifdef DIVPIPE_OVF_EN
        .ovf       (ovf),
`endif
        .out_tag   (out_tag)
    );

    task automatic test_reset();
        #2;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
        checks++; if ({q, r} !== 64'd0) begin errors++; $display("FAIL reset_qr got=%h exp=0", {q, r}); end
        checks++; if (out_tag !== 4'd0) begin errors++; $display("FAIL reset_tag got=%0d exp=0", out_tag); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
        @(negedge clk); rstn = 1'b1;
    endtask

    task automatic test_basic();
        logic [63:0] vx [3];
        logic [31:0] vd [3], eq [3], er [3];
        logic [3:0]  vt [3];
        int lat;
        vx[0] = 64'd100;                 vd[0] = 32'd7;          eq[0] = 32'd14;         er[0] = 32'd2; vt[0] = 4'd3;
        vx[1] = 64'h0000_0001_0000_0000; vd[1] = 32'd3;          eq[1] = 32'h5555_5555;  er[1] = 32'd1; vt[1] = 4'd9;
        vx[2] = 64'h0000_0002_FFFF_FFFF; vd[2] = 32'hFFFF_FFFF;  eq[2] = 32'd3;          er[2] = 32'd2; vt[2] = 4'd12;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1; x = vx[i]; d = vd[i]; in_tag = vt[i]; out_ready = 1'b1;
            @(posedge clk); #1 in_valid = 1'b0;
            lat = 0;
            @(negedge clk);
            while (!out_valid && lat < 20) begin @(negedge clk); lat++; end
            checks++; if (lat !== 3) begin errors++; $display("FAIL basic%0d_latency got=%0d exp=3", i, lat); end
            checks++; if (q !== eq[i]) begin errors++; $display("FAIL basic%0d_q got=%h exp=%h", i, q, eq[i]); end
            checks++; if (r !== er[i]) begin errors++; $display("FAIL basic%0d_r got=%h exp=%h", i, r, er[i]); end
            checks++; if (out_tag !== vt[i]) begin errors++; $display("FAIL basic%0d_tag got=%0d exp=%0d", i, out_tag, vt[i]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [67:0] expq [$];
        logic [67:0] e;
        logic [63:0] xx;
        logic [31:0] dd;
        int sent = 0, got = 0, first_cyc = -1, last_cyc = -1;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 1200 && (sent < 1000 || expq.size() > 0); cyc++) begin
            @(negedge clk);
            if (sent < 1000) begin
                dd = $urandom;
                if (dd == 0 || sent % 50 == 0) dd = 32'hFFFF_FFFF;
                xx = {$urandom % dd, $urandom};
                in_valid = 1'b1; x = xx; d = dd; in_tag = sent[3:0];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid) begin
                checks++;
                if (expq.size() == 0) begin
                    errors++; $display("FAIL b2b_extra got q=%h r=%h", q, r);
                end else begin
                    e = expq.pop_front();
                    if ({q, r, out_tag} !== e) begin
                        errors++; $display("FAIL b2b_result%0d got=%h exp=%h", got, {q, r, out_tag}, e);
                    end
                end
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                got++;
            end
            if (in_valid && in_ready) begin
                expq.push_back({32'(xx / {32'd0, dd}), 32'(xx % {32'd0, dd}), in_tag});
                sent++;
            end
        end
        in_valid = 1'b0;
        checks++; if (got !== 1000 || sent !== 1000) begin errors++; $display("FAIL b2b_count got=%0d sent=%0d exp=1000", got, sent); end
        checks++; if (last_cyc - first_cyc !== 999) begin errors++; $display("FAIL b2b_throughput got_span=%0d exp=999", last_cyc - first_cyc); end
    endtask

    task automatic test_stall();
        logic [67:0] expq [$];
        logic [67:0] e, held;
        logic        held_v = 1'b0, prev_stall = 1'b0;
        logic [63:0] xx;
        logic [31:0] dd;
        int sent = 0, got = 0;
        for (int cyc = 0; cyc < 3000 && (sent < 300 || expq.size() > 0); cyc++) begin
            @(negedge clk);
            if (prev_stall) begin
                checks++;
                if ({out_valid, q, r, out_tag} !== {held_v, held}) begin
                    errors++; $display("FAIL stall_hold got=%h exp=%h", {out_valid, q, r, out_tag}, {held_v, held});
                end
            end
            out_ready = ($urandom_range(0, 99) >= 30);
            if (sent < 300 && $urandom_range(0, 3) != 0) begin
                dd = $urandom | 32'd1;
                xx = {$urandom % dd, $urandom};
                in_valid = 1'b1; x = xx; d = dd; in_tag = 4'($urandom);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            checks++;
            if (in_ready !== !(out_valid && !out_ready)) begin
                errors++; $display("FAIL stall_in_ready got=%0b out_valid=%0b out_ready=%0b", in_ready, out_valid, out_ready);
            end
            if (out_valid && out_ready) begin
                checks++;
                if (expq.size() == 0) begin
                    errors++; $display("FAIL stall_extra got q=%h r=%h", q, r);
                end else begin
                    e = expq.pop_front();
                    if ({q, r, out_tag} !== e) begin
                        errors++; $display("FAIL stall_result%0d got=%h exp=%h", got, {q, r, out_tag}, e);
                    end
                end
                got++;
            end
            if (in_valid && in_ready) begin
                expq.push_back({32'(xx / {32'd0, dd}), 32'(xx % {32'd0, dd}), in_tag});
                sent++;
            end
            prev_stall = out_valid && !out_ready;
            held_v     = out_valid;
            held       = {q, r, out_tag};
        end
        in_valid = 1'b0; out_ready = 1'b1;
        checks++;
        if (sent !== 300 || got !== 300 || expq.size() != 0) begin
            errors++; $display("FAIL stall_count sent=%0d got=%0d left=%0d exp=300/300/0", sent, got, expq.size());
        end
    endtask

`ifdef DIVPIPE_OVF_EN
    task automatic test_ovf();
        logic [63:0] vx [3];
        logic [31:0] vd [3];
        logic [64:0] ex [3];
        int n = 0;
        vx[0] = {32'd5, 32'h1234_5678}; vd[0] = 32'd5; ex[0] = {1'b1, 32'hFFFF_FFFF, 32'd0};
        vx[1] = 64'd77;                 vd[1] = 32'd0; ex[1] = {1'b1, 32'hFFFF_FFFF, 32'd0};
        vx[2] = 64'd100;                vd[2] = 32'd7; ex[2] = {1'b0, 32'd14, 32'd2};
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 20 && n < 3; cyc++) begin
            @(negedge clk);
            if (cyc < 3) begin in_valid = 1'b1; x = vx[cyc]; d = vd[cyc]; in_tag = 4'(cyc); end
            else in_valid = 1'b0;
            #1;
            if (out_valid) begin
                checks++;
                if ({ovf, q, r} !== ex[n]) begin errors++; $display("FAIL ovf%0d got=%h exp=%h", n, {ovf, q, r}, ex[n]); end
                n++;
            end
        end
        in_valid = 1'b0;
        checks++; if (n !== 3) begin errors++; $display("FAIL ovf_count got=%0d exp=3", n); end
    endtask
`endif

    task automatic test_reset_midflight();
        int lat;
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            in_valid = 1'b1; x = 64'd50 + 64'(i); d = 32'd6; in_tag = 4'(i + 1);
        end
        @(negedge clk); in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL mid_fill got valid=%0b ready=%0b exp 1/0", out_valid, in_ready); end
        #2 rstn = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid got=%0b exp=0", out_valid); end
        checks++; if ({q, r, out_tag} !== 68'd0) begin errors++; $display("FAIL mid_outputs got=%h exp=0", {q, r, out_tag}); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready got=%0b exp=1", in_ready); end
        @(negedge clk); rstn = 1'b1;
        @(negedge clk);
        in_valid = 1'b1; x = 64'd1000; d = 32'd9; in_tag = 4'd5; out_ready = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        lat = 0;
        @(negedge clk);
        while (!out_valid && lat < 20) begin @(negedge clk); lat++; end
        checks++; if (lat !== 3) begin errors++; $display("FAIL post_reset_latency got=%0d exp=3", lat); end
        checks++;
        if ({q, r, out_tag} !== {32'd111, 32'd1, 4'd5}) begin
            errors++; $display("FAIL post_reset_result got=%h exp=%h", {q, r, out_tag}, {32'd111, 32'd1, 4'd5});
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_stall();
`ifdef DIVPIPE_OVF_EN
        test_ovf();
`endif
        test_reset_midflight();
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
